// File: rtl/alu_reservation_station.sv
// ALU reservation station with CDB snooping and a registered result slot.
// Issues go to the lowest free entry; the lowest ready entry dispatches first.
package lc3b_types;
    typedef struct packed {
        logic        valid;
        logic [2:0]  tag;
        logic [15:0] data;
    } CDB;
endpackage

module alu_reservation_station
    import lc3b_types::*;
#(
    parameter int ENTRIES = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        issue_valid,
    input  logic [1:0]  issue_op,
    input  logic [2:0]  issue_dest,
    input  logic        issue_j_rdy,
    input  logic        issue_k_rdy,
    input  logic [15:0] issue_Vj,
    input  logic [15:0] issue_Vk,
    input  logic [2:0]  issue_Qj,
    input  logic [2:0]  issue_Qk,
    output logic        rs_full,
    input  CDB          CDB_in,
    output CDB          RS_CDB_out,
    input  logic        RS_flush,
    input  logic        flush_all
);

    localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    typedef struct packed {
        logic        busy;
        logic [1:0]  op;
        logic [2:0]  dest;
        logic [15:0] Vj;
        logic [2:0]  Qj;
        logic        j_rdy;
        logic [15:0] Vk;
        logic [2:0]  Qk;
        logic        k_rdy;
    } rs_entry_t;

    rs_entry_t [ENTRIES-1:0] ent_q;
    rs_entry_t [ENTRIES-1:0] ent_d;
    rs_entry_t               new_ent;
    rs_entry_t               disp_ent;

    logic          out_valid_q;
    logic          out_valid_d;
    logic [2:0]    out_tag_q;
    logic [2:0]    out_tag_d;
    logic [15:0]   out_data_q;
    logic [15:0]   out_data_d;

    logic          alloc_ok;
    logic [IW-1:0] alloc_idx;
    logic          disp_ok;
    logic [IW-1:0] disp_idx;
    logic          slot_free;
    logic [15:0]   disp_res;

    function automatic logic [15:0] alu_f(
        input logic [1:0]  op,
        input logic [15:0] a,
        input logic [15:0] b
    );
        logic [15:0] r;
        unique case (op)
            2'b00: r = a + b;
            2'b01: r = a & b;
            2'b10: r = ~a;
            2'b11: r = b;
        endcase
        return r;
    endfunction

    // Pick lowest free slot for issue and lowest ready slot for dispatch.
    always_comb begin
        alloc_ok  = 1'b0;
        alloc_idx = '0;
        disp_ok   = 1'b0;
        disp_idx  = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!ent_q[i].busy) begin
                alloc_ok  = 1'b1;
                alloc_idx = IW'(i);
            end
            if (ent_q[i].busy && ent_q[i].j_rdy && ent_q[i].k_rdy) begin
                disp_ok  = 1'b1;
                disp_idx = IW'(i);
            end
        end
    end

    assign rs_full   = ~alloc_ok;
    assign slot_free = ~out_valid_q | RS_flush;
    assign disp_ent  = ent_q[disp_idx];
    assign disp_res  = alu_f(disp_ent.op, disp_ent.Vj, disp_ent.Vk);

    // Build the incoming entry, bypassing operands broadcast this cycle.
    always_comb begin
        new_ent       = '0;
        new_ent.busy  = 1'b1;
        new_ent.op    = issue_op;
        new_ent.dest  = issue_dest;
        new_ent.Vj    = issue_Vj;
        new_ent.Qj    = issue_Qj;
        new_ent.j_rdy = issue_j_rdy;
        new_ent.Vk    = issue_Vk;
        new_ent.Qk    = issue_Qk;
        new_ent.k_rdy = issue_k_rdy;
        if (!issue_j_rdy && CDB_in.valid && CDB_in.tag == issue_Qj) begin
            new_ent.Vj    = CDB_in.data;
            new_ent.j_rdy = 1'b1;
        end
        if (!issue_k_rdy && CDB_in.valid && CDB_in.tag == issue_Qk) begin
            new_ent.Vk    = CDB_in.data;
            new_ent.k_rdy = 1'b1;
        end
    end

    // Next state: squash wins, else snoop, dispatch and issue together.
    always_comb begin
        ent_d       = ent_q;
        out_valid_d = out_valid_q;
        out_tag_d   = out_tag_q;
        out_data_d  = out_data_q;
        if (flush_all) begin
            ent_d       = '0;
            out_valid_d = 1'b0;
            out_tag_d   = '0;
            out_data_d  = '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (ent_q[i].busy && CDB_in.valid) begin
                    if (!ent_q[i].j_rdy && CDB_in.tag == ent_q[i].Qj) begin
                        ent_d[i].Vj    = CDB_in.data;
                        ent_d[i].j_rdy = 1'b1;
                    end
                    if (!ent_q[i].k_rdy && CDB_in.tag == ent_q[i].Qk) begin
                        ent_d[i].Vk    = CDB_in.data;
                        ent_d[i].k_rdy = 1'b1;
                    end
                end
            end
            if (disp_ok && slot_free) begin
                out_valid_d            = 1'b1;
                out_tag_d              = disp_ent.dest;
                out_data_d             = disp_res;
                ent_d[disp_idx].busy   = 1'b0;
            end else if (out_valid_q && RS_flush) begin
                out_valid_d = 1'b0;
                out_tag_d   = '0;
                out_data_d  = '0;
            end
            if (issue_valid && alloc_ok) begin
                ent_d[alloc_idx] = new_ent;
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ent_q       <= '0;
            out_valid_q <= 1'b0;
            out_tag_q   <= '0;
            out_data_q  <= '0;
        end else begin
            ent_q       <= ent_d;
            out_valid_q <= out_valid_d;
            out_tag_q   <= out_tag_d;
            out_data_q  <= out_data_d;
        end
    end

    // A granted result is hidden in its grant cycle.
    always_comb begin
        RS_CDB_out       = '0;
        RS_CDB_out.valid = out_valid_q & ~RS_flush;
        if (RS_CDB_out.valid) begin
            RS_CDB_out.tag  = out_tag_q;
            RS_CDB_out.data = out_data_q;
        end
    end

endmodule

// File: doc/alu_reservation_station.md
ALU_RESERVATION_STATION -- requirements
Module: alu_reservation_station

Interface
REQ-001 Parameter ENTRIES, default 3; number of reservation-station entries (1..4).
REQ-002 Type CDB (lc3b_types) SHALL be {valid 1b, tag 3b ROB index, data 16b}, with tag and data zero whenever valid is 0.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 issue_valid  input  1  an instruction is presented for issue this cycle.
REQ-006 issue_op  input  2  ALU operation: 00 ADD, 01 AND, 10 NOT, 11 PASS.
REQ-007 issue_dest  input  3  ROB tag of the result.
REQ-008 issue_j_rdy / issue_k_rdy  input  1 each  operand value is present.
REQ-009 issue_Vj / issue_Vk  input  16 each  operand values, used when the ready bit is 1.
REQ-010 issue_Qj / issue_Qk  input  3 each  producing ROB tag, used when the ready bit is 0.
REQ-011 rs_full  output  1  all entries are busy, driven from registered state only.
REQ-012 CDB_in  input  CDB  broadcast bus from the CDB arbiter, snooped for operands.
REQ-013 RS_CDB_out  output  CDB  result request to the arbiter; this port drives one RS_CDB_in slot.
REQ-014 RS_flush  input  1  grant/acknowledge from the arbiter; a registered signal.
REQ-015 flush_all  input  1  synchronous squash of all contents (branch mispredict).

Function
REQ-016 Each entry SHALL hold busy, op, dest, Vj, Qj, j_rdy, Vk, Qk, k_rdy.
REQ-017 Issue acceptance: if issue_valid=1 and rs_full=0, the issue SHALL be written into the lowest-index non-busy entry, which becomes busy at the next edge.
REQ-018 If issue_valid=1 and rs_full=1, the issue SHALL be ignored with no state change.
REQ-019 An entry freed in the same cycle SHALL NOT be reused until the following cycle.
REQ-020 Snoop: for every busy entry with j_rdy=0, if CDB_in.valid=1 and CDB_in.tag=Qj, the entry SHALL latch Vj=CDB_in.data and set j_rdy=1 at the edge; the same rule applies to k.
REQ-021 Issue bypass: an issuing operand with rdy=0 whose Q equals CDB_in.tag while CDB_in.valid=1 SHALL be written as ready with CDB_in.data.
REQ-022 An operand captured by snoop SHALL be eligible for dispatch no earlier than the next cycle; readiness is registered.
REQ-023 Dispatch eligibility: busy=1, j_rdy=1 and k_rdy=1.
REQ-024 Dispatch occurs when at least one entry is eligible and the output slot is free, meaning out_valid=0 or (out_valid=1 and RS_flush=1).
REQ-025 Dispatch SHALL select the lowest-index eligible entry, load the output register with {1, dest, ALU result}, and clear that entry's busy bit at the same edge.
REQ-026 ALU results: ADD = (Vj+Vk) mod 2^16; AND = Vj & Vk; NOT = ~Vj; PASS = Vk.
REQ-027 Latency from an entry being eligible with the slot free to RS_CDB_out.valid=1 SHALL be one cycle.
REQ-028 RS_CDB_out.valid SHALL equal out_valid AND NOT RS_flush, so the arbiter never samples an acknowledged result twice.
REQ-029 RS_CDB_out tag and data SHALL be zero when RS_CDB_out.valid=0.
REQ-030 At an edge with out_valid=1 and RS_flush=1, the output register SHALL clear, unless a dispatch reloads it at the same edge.
REQ-031 An RS_flush arriving while out_valid=0 SHALL be ignored.
REQ-032 flush_all=1 SHALL clear all busy bits and out_valid at the next edge.
REQ-033 flush_all SHALL take priority over issue, snoop, and dispatch in the same cycle.

Reset
REQ-034 While reset_n=0: all entries not busy, all entry fields zero, out_valid=0, RS_CDB_out=0, rs_full=0.
REQ-035 Reset SHALL take effect immediately, independent of clk, including mid-dispatch or while a result is pending a grant.
REQ-036 The first issue SHALL be accepted at the first rising edge after reset_n rises.

Verification
REQ-037 Issue ADD, Vj=0x0003, Vk=0x0004, both ready, dest=5 -> next cycle RS_CDB_out={1,5,0x0007}; RS_flush=1 for one cycle -> RS_CDB_out.valid=0 in that cycle and the output clears.
REQ-038 Issue AND with Qj=2 pending and Vk=0x00FF; CDB_in={1,2,0x1234} -> entry captures Vj; result {1,dest,0x0034} appears two cycles after the broadcast.
REQ-039 Fill all ENTRIES, then issue again -> rs_full=1 and the extra issue is dropped; after one dispatch, rs_full=0 the next cycle.
REQ-040 Hold RS_flush=0 with out_valid=1 and two eligible entries -> the output stays stable and no dispatch occurs; grant -> the lowest index dispatches at the same edge as the clear, with back-to-back valid results.
REQ-041 Issue bypass: issue with Qk=4 while CDB_in={1,4,0xFFFF}, op PASS -> result 0xFFFF one cycle later.
REQ-042 flush_all or reset_n=0 with a pending result and busy entries -> all outputs zero and rs_full=0; a subsequent issue goes to entry 0.
